// File: rtl/sram_bus_sampler.sv
// SRAM bus capture: synchronises read strobe and address/data, detects strobe edges,
// and buffers {address, data, edge} samples in a first-word-fall-through FIFO.
module sram_bus_sampler #(
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     read_i,
   input  logic [ADDR_W-1:0]        address_i,
   input  logic [DATA_W-1:0]        data_i,
   input  logic                     enable_i,
   input  logic                     clear_overflow_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [ADDR_W-1:0]        out_address_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic                     out_edge_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o,
   output logic [15:0]              drop_count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int BUS_W = 1 + ADDR_W + DATA_W;
   localparam int ENT_W = ADDR_W + DATA_W + 1;
   // Detection waits until prev_read holds a value that travelled the whole chain,
   // so a strobe held high through reset never looks like a rising edge.
   localparam logic [2:0] PRIME_N = 3'(SYNC_STAGES + 1);

   logic [BUS_W-1:0]  in_bus;
   logic [BUS_W-1:0]  s_bus;
   logic              s_read;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_data;

   assign in_bus = {read_i, address_i, data_i};

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_bus = in_bus;
      end else begin : g_sync
         logic [BUS_W-1:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
               sync_q[0] <= in_bus;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign s_bus = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign s_read = s_bus[BUS_W-1];
   assign s_addr = s_bus[ADDR_W+DATA_W-1:DATA_W];
   assign s_data = s_bus[DATA_W-1:0];

   logic       prev_read_q;
   logic [2:0] prime_cnt_q, prime_cnt_d;
   logic       primed;
   logic       rise, fall, qual_edge;

   assign primed      = (prime_cnt_q == PRIME_N);
   assign prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 3'd1;
   assign rise        = s_read & ~prev_read_q;
   assign fall        = ~s_read & prev_read_q;
   assign qual_edge   = (EDGE_MODE == 0) ? rise :
                        (EDGE_MODE == 1) ? fall : (rise | fall);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_read_q <= 1'b0;
         prime_cnt_q <= '0;
      end else begin
         prev_read_q <= s_read;
         prime_cnt_q <= prime_cnt_d;
      end
   end

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             push_req, full, pop, push, drop;
   logic [ENT_W-1:0] head;

   assign push_req = qual_edge & enable_i & primed;
   assign full     = (level_q == LVL_W'(DEPTH));
   assign pop      = out_valid_o & out_ready_i;
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      // A drop in the clearing cycle still counts, so it survives the clear.
      if (clear_overflow_i) begin
         overflow_d = drop;
         drop_cnt_d = drop ? 16'd1 : 16'd0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {s_addr, s_data, rise};
   end

   assign head          = mem_q[rd_ptr_q];
   assign out_valid_o   = (level_q != '0);
   // Masking keeps the head fields at zero after reset while storage is unwritten.
   assign out_address_o = out_valid_o ? head[ENT_W-1:DATA_W+1] : '0;
   assign out_data_o    = out_valid_o ? head[DATA_W:1]         : '0;
   assign out_edge_o    = out_valid_o ? head[0]                : 1'b0;
   assign level_o       = level_q;
   assign overflow_o    = overflow_q;
   assign drop_count_o  = drop_cnt_q;

endmodule
